motor_driver: RTL and testbench
===============================

Name: motor_driver

Overview:
Executes the motion commands issued by the robot navigation controller and returns its `done` handshake.
- Decodes the five command lines (stop_motor, front_motor, turn_left, turn_right, rotate) into PWM/direction drive for the left and right wheels.
- Times turn and rotate manoeuvres with cycle counters and raises `done` when each completes.
- Sits between the navigation controller and the wheel H-bridges.

Parameters:
PWM_PERIOD, 16, PWM frame length in clk cycles (>=2)
PWM_DUTY, 12, high cycles per frame at full speed (1..PWM_PERIOD)
TURN_CYCLES, 200, clk cycles a turn_left/turn_right manoeuvre drives the wheels (>=1)
ROTATE_CYCLES, 400, clk cycles a rotate manoeuvre drives the wheels (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
stop_motor  input  1  command: halt all wheels
front_motor  input  1  command: drive forward, continuous
turn_left  input  1  command: timed left turn
turn_right  input  1  command: timed right turn
rotate  input  1  command: timed spin in place
done  output  1  timed manoeuvre complete; held until its command drops
busy  output  1  timed manoeuvre in progress
left_pwm  output  1  left wheel enable (PWM)
left_dir  output  1  left wheel direction, 1=forward
right_pwm  output  1  right wheel enable (PWM)
right_dir  output  1  right wheel direction, 1=forward

Behaviour:
- Reset (synchronous, active-high, clk):
  - state=IDLE; manoeuvre counter=0; pwm_cnt=0.
  - All outputs 0.
  - Reset mid-manoeuvre aborts it at that edge; no done.
- Command priority when several inputs are high: stop_motor > rotate > turn_left > turn_right > front_motor. The active command is the highest-priority input that is high, or none.
- States: IDLE, STOP, FWD, TURN_L, TURN_R, ROT, DONE.
- Transitions, evaluated every edge:
  - IDLE/STOP/FWD → state of the current active command; no command → IDLE.
  - TURN_L/TURN_R/ROT:
    - If the active command still matches and counter==N-1 (N=TURN_CYCLES or ROTATE_CYCLES) → DONE.
    - If it still matches and counter<N-1 → stay, counter+1.
    - If the active command differs → go to the new command's state with counter=0; no done is raised.
  - DONE: stay while the completed command remains the active command. Otherwise → state of the new active command, or IDLE.
- Counter and PWM reset:
  - Counter clears on every state change.
  - pwm_cnt clears on every state change, else counts 0..PWM_PERIOD-1 and wraps.
  - pwm_on = (pwm_cnt < duty), with duty=PWM_DUTY.
- Outputs are decoded from registered state and pwm_cnt. A command sampled at edge N is reflected in the outputs from edge N onward (1-cycle latency from command assertion).
- Drive per state:
  - IDLE, STOP, DONE: all wheel outputs 0.
  - FWD: left_pwm=right_pwm=pwm_on; left_dir=right_dir=1.
  - TURN_L: left_pwm=0, right_pwm=pwm_on, right_dir=1, left_dir=0.
  - TURN_R: right_pwm=0, left_pwm=pwm_on, left_dir=1, right_dir=0.
  - ROT: left_pwm=right_pwm=pwm_on; left_dir=1, right_dir=0.
- Manoeuvre length: wheels driven for exactly N cycles. done=1 from edge N after entry (state DONE) until the command drops.
- busy=1 in TURN_L/TURN_R/ROT only. done=1 in DONE only. done and busy are never both high.
- A continuously held command produces one completion only: DONE does not restart the manoeuvre. The command must drop and be reasserted to run again.

Optional Feature:
MOTOR_SOFT_START_EN
- Defined:
  - On entry to FWD or ROT, duty starts at 1 and increments by 1 at each pwm_cnt wrap until it reaches PWM_DUTY, then holds.
  - Duty resets to 1 on any state change.
  - Turn states use full PWM_DUTY.
- Undefined: duty is PWM_DUTY in all driving states; no ramp register is synthesised.

Test Plan:
Bench parameters: PWM_PERIOD=4, PWM_DUTY=3, TURN_CYCLES=10, ROTATE_CYCLES=20.
1. Reset held 3 cycles with front_motor=1 → all outputs 0 throughout. After release, left_pwm/right_pwm follow the pattern 1,1,1,0 repeating, with dirs=1.
2. turn_left=1 held → busy=1 and right_pwm pattern 1110 for exactly 10 cycles, left_pwm=0. Then done=1, busy=0, wheels 0. Dropping turn_left → done=0 next edge, state IDLE.
3. rotate=1 held → left_dir=1, right_dir=0, both PWM active 20 cycles, then done=1 held; holding rotate 50 more cycles → no restart, done stays 1.
4. turn_right asserted, stop_motor raised at cycle 4 → at the next edge all wheel outputs 0, busy=0, done never asserts.
5. front_motor=1 and turn_left=1 together → TURN_L selected (priority). After 10 cycles done=1. Dropping turn_left with front_motor still 1 → FWD next edge, done=0.
6. MOTOR_SOFT_START_EN defined, front_motor=1 → high cycles per frame 1,2,3,3,… across successive PWM frames.

Source files
------------

// File: rtl/motor_driver.sv
// motor_driver: decodes the navigation controller's motion commands into
// left/right wheel PWM + direction, times turn and rotate manoeuvres with a
// cycle counter and returns a done handshake.
// Optional build macro: MOTOR_SOFT_START_EN (duty ramp on entry to FWD/ROT).
//
// Command/done handshake: a command line is a level. A timed manoeuvre runs
// while its command stays the highest-priority active one; on completion
// done rises and stays high until that command drops (or is overridden), and
// the manoeuvre does not restart until the command is released and asserted
// again. busy and done are mutually exclusive.
module motor_driver #(
   parameter int PWM_PERIOD    = 16,
   parameter int PWM_DUTY      = 12,
   parameter int TURN_CYCLES   = 200,
   parameter int ROTATE_CYCLES = 400
) (
   input  logic clk,
   input  logic reset,
   input  logic stop_motor,
   input  logic front_motor,
   input  logic turn_left,
   input  logic turn_right,
   input  logic rotate,
   output logic done,
   output logic busy,
   output logic left_pwm,
   output logic left_dir,
   output logic right_pwm,
   output logic right_dir
);

   localparam int MAN_MAX = (ROTATE_CYCLES > TURN_CYCLES) ? ROTATE_CYCLES : TURN_CYCLES;
   localparam int CNT_W   = $clog2(MAN_MAX + 1);
   // One extra code so a duty equal to the full period is representable.
   localparam int PWM_W   = $clog2(PWM_PERIOD + 1);

   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
   localparam logic [CNT_W-1:0] ROT_LAST  = CNT_W'(ROTATE_CYCLES - 1);
   localparam logic [PWM_W-1:0] PWM_LAST  = PWM_W'(PWM_PERIOD - 1);
   localparam logic [PWM_W-1:0] DUTY_FULL = PWM_W'(PWM_DUTY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STOP,
      S_FWD,
      S_TURN_L,
      S_TURN_R,
      S_ROT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   state_t           done_cmd_q, done_cmd_d;   // manoeuvre that completed
   state_t           cmd_state;                // state requested by the inputs
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PWM_W-1:0] pwm_q, pwm_d;
   logic [PWM_W-1:0] duty;
   logic             state_chg;
   logic             pwm_wrap;
   logic             pwm_on;

   // Priority decode of the command lines into the state they request.
   always_comb begin
      cmd_state = S_IDLE;
      if (stop_motor)       cmd_state = S_STOP;
      else if (rotate)      cmd_state = S_ROT;
      else if (turn_left)   cmd_state = S_TURN_L;
      else if (turn_right)  cmd_state = S_TURN_R;
      else if (front_motor) cmd_state = S_FWD;
   end

   // Next-state, manoeuvre counter and PWM counter.
   always_comb begin
      state_d    = state_q;
      done_cmd_d = done_cmd_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE, S_STOP, S_FWD: state_d = cmd_state;
         S_TURN_L, S_TURN_R, S_ROT: begin
            if (cmd_state == state_q) begin
               if (cnt_q == ((state_q == S_ROT) ? ROT_LAST : TURN_LAST)) begin
                  state_d    = S_DONE;
                  done_cmd_d = state_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               state_d = cmd_state;
            end
         end
         S_DONE: begin
            if (cmd_state != done_cmd_q) state_d = cmd_state;
         end
         default: state_d = S_IDLE;
      endcase
      state_chg = (state_d != state_q);
      pwm_wrap  = (pwm_q == PWM_LAST);
      if (state_chg) begin
         cnt_d = '0;
         pwm_d = '0;
      end else if (pwm_wrap) begin
         pwm_d = '0;
      end else begin
         pwm_d = pwm_q + 1'b1;
      end
   end

   // State, counter and PWM registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         done_cmd_q <= S_IDLE;
         cnt_q      <= '0;
         pwm_q      <= '0;
      end else begin
         state_q    <= state_d;
         done_cmd_q <= done_cmd_d;
         cnt_q      <= cnt_d;
         pwm_q      <= pwm_d;
      end
   end

`ifdef MOTOR_SOFT_START_EN
   logic [PWM_W-1:0] ramp_q, ramp_d;

   // Soft-start ramp: restart at 1 on any state change, step once per frame.
   always_comb begin
      ramp_d = ramp_q;
      if (state_chg)                           ramp_d = PWM_W'(1);
      else if (pwm_wrap && ramp_q < DUTY_FULL) ramp_d = ramp_q + 1'b1;
   end

   // Ramp register.
   always_ff @(posedge clk) begin
      if (reset) ramp_q <= PWM_W'(1);
      else       ramp_q <= ramp_d;
   end

   assign duty = (state_q == S_FWD || state_q == S_ROT) ? ramp_q : DUTY_FULL;
`else
   assign duty = DUTY_FULL;
`endif

   assign pwm_on = (pwm_q < duty);

   // Wheel drive and status decoded from the registered state.
   always_comb begin
      done      = 1'b0;
      busy      = 1'b0;
      left_pwm  = 1'b0;
      left_dir  = 1'b0;
      right_pwm = 1'b0;
      right_dir = 1'b0;
      case (state_q)
         S_FWD: begin
            left_pwm  = pwm_on;
            right_pwm = pwm_on;
            left_dir  = 1'b1;
            right_dir = 1'b1;
         end
         S_TURN_L: begin
            busy      = 1'b1;
            right_pwm = pwm_on;
            right_dir = 1'b1;
         end
         S_TURN_R: begin
            busy      = 1'b1;
            left_pwm  = pwm_on;
            left_dir  = 1'b1;
         end
         S_ROT: begin
            busy      = 1'b1;
            left_pwm  = pwm_on;
            right_pwm = pwm_on;
            left_dir  = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_motor_driver.sv
// tb_motor_driver: directed stimulus for motor_driver with an expected-value
// queue; each step drives commands, pushes the expected output vector and
// checks it half a cycle after the edge.
// Output vector order: {done, busy, left_pwm, left_dir, right_pwm, right_dir}.
module tb_motor_driver;

   localparam int PWM_PERIOD    = 4;
   localparam int PWM_DUTY      = 3;
   localparam int TURN_CYCLES   = 10;
   localparam int ROTATE_CYCLES = 20;

   // Command encodings {stop, rotate, turn_left, turn_right, front}.
   localparam logic [4:0] C_NONE = 5'b00000;
   localparam logic [4:0] C_FWD  = 5'b00001;
   localparam logic [4:0] C_TR   = 5'b00010;
   localparam logic [4:0] C_TL   = 5'b00100;
   localparam logic [4:0] C_ROT  = 5'b01000;
   localparam logic [4:0] C_STOP = 5'b10000;

   localparam logic [5:0] V_IDLE = 6'b000000;
   localparam logic [5:0] V_DONE = 6'b100000;

   logic clk;
   logic reset;
   logic stop_motor, front_motor, turn_left, turn_right, rotate;
   logic done, busy, left_pwm, left_dir, right_pwm, right_dir;

   logic [5:0] exp_q[$];
   string      tag_q[$];
   int         cmp_cnt  = 0;
   int         fail_cnt = 0;

   motor_driver #(
      .PWM_PERIOD   (PWM_PERIOD),
      .PWM_DUTY     (PWM_DUTY),
      .TURN_CYCLES  (TURN_CYCLES),
      .ROTATE_CYCLES(ROTATE_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .stop_motor (stop_motor),
      .front_motor(front_motor),
      .turn_left  (turn_left),
      .turn_right (turn_right),
      .rotate     (rotate),
      .done       (done),
      .busy       (busy),
      .left_pwm   (left_pwm),
      .left_dir   (left_dir),
      .right_pwm  (right_pwm),
      .right_dir  (right_dir)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected PWM level k cycles after entering a driving state.
   function automatic logic exp_pwm(input int k, input bit ramp);
      int duty;
      duty = PWM_DUTY;
`ifdef MOTOR_SOFT_START_EN
      if (ramp && (k / PWM_PERIOD) + 1 < PWM_DUTY) duty = (k / PWM_PERIOD) + 1;
`else
      if (ramp) duty = PWM_DUTY;
`endif
      return (k % PWM_PERIOD) < duty;
   endfunction

   function automatic logic [5:0] v_fwd(input int k);
      logic p;
      p = exp_pwm(k, 1'b1);
      return {1'b0, 1'b0, p, 1'b1, p, 1'b1};
   endfunction

   function automatic logic [5:0] v_tl(input int k);
      logic p;
      p = exp_pwm(k, 1'b0);
      return {1'b0, 1'b1, 1'b0, 1'b0, p, 1'b1};
   endfunction

   function automatic logic [5:0] v_tr(input int k);
      logic p;
      p = exp_pwm(k, 1'b0);
      return {1'b0, 1'b1, p, 1'b1, 1'b0, 1'b0};
   endfunction

   function automatic logic [5:0] v_rot(input int k);
      logic p;
      p = exp_pwm(k, 1'b1);
      return {1'b0, 1'b1, p, 1'b1, p, 1'b0};
   endfunction

   // Pop the oldest expectation and compare it with the DUT outputs.
   task automatic check_out();
      logic [5:0] e;
      logic [5:0] obs;
      string      t;
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = {done, busy, left_pwm, left_dir, right_pwm, right_dir};
      cmp_cnt++;
      assert (obs === e) else begin
         fail_cnt++;
         $error("FAIL %s: observed %b expected %b", t, obs, e);
      end
   endtask

   // One clock: drive at the falling edge, check at the next falling edge.
   task automatic step(input logic rst, input logic [4:0] cmd,
                       input logic [5:0] exp, input string tag);
      reset = rst;
      {stop_motor, rotate, turn_left, turn_right, front_motor} = cmd;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(posedge clk);
      @(negedge clk);
      check_out();
   endtask

   // Directed sequence.
   initial begin
      reset = 1'b1;
      {stop_motor, rotate, turn_left, turn_right, front_motor} = C_NONE;
      @(negedge clk);

      // Reset held with front_motor high: everything stays low.
      for (int i = 0; i < 3; i++) step(1'b1, C_FWD, V_IDLE, "reset_hold");
      // Forward drive after release (ramped when soft start is built in).
      for (int k = 0; k < 12; k++) step(1'b0, C_FWD, v_fwd(k), "fwd_pwm");

      // Timed left turn, done held, then release to IDLE.
      for (int k = 0; k < TURN_CYCLES; k++) step(1'b0, C_TL, v_tl(k), "turn_l_run");
      for (int i = 0; i < 3; i++) step(1'b0, C_TL, V_DONE, "turn_l_done");
      step(1'b0, C_NONE, V_IDLE, "turn_l_release");

      // Rotate, then held for 50 more cycles with no restart.
      for (int k = 0; k < ROTATE_CYCLES; k++) step(1'b0, C_ROT, v_rot(k), "rot_run");
      for (int i = 0; i < 50; i++) step(1'b0, C_ROT, V_DONE, "rot_done_hold");
      step(1'b0, C_NONE, V_IDLE, "rot_release");

      // Right turn aborted by stop at cycle 4: no done ever.
      for (int k = 0; k < 4; k++) step(1'b0, C_TR, v_tr(k), "turn_r_run");
      for (int i = 0; i < 12; i++) step(1'b0, C_STOP | C_TR, V_IDLE, "stop_abort");
      step(1'b0, C_NONE, V_IDLE, "stop_release");

      // front + turn_left together: turn wins, then drop back to forward.
      for (int k = 0; k < TURN_CYCLES; k++) step(1'b0, C_FWD | C_TL, v_tl(k), "prio_turn_l");
      for (int i = 0; i < 2; i++) step(1'b0, C_FWD | C_TL, V_DONE, "prio_done");
      for (int k = 0; k < 8; k++) step(1'b0, C_FWD, v_fwd(k), "prio_back_fwd");

      // Command change mid-turn restarts the count for the new manoeuvre.
      for (int k = 0; k < 3; k++) step(1'b0, C_TL, v_tl(k), "switch_tl");
      for (int k = 0; k < TURN_CYCLES; k++) step(1'b0, C_TR, v_tr(k), "switch_tr_full");
      step(1'b0, C_TR, V_DONE, "switch_tr_done");
      step(1'b0, C_NONE, V_IDLE, "switch_release");

      // Reset mid-rotate aborts; rotate held through release runs afresh.
      for (int k = 0; k < 5; k++) step(1'b0, C_ROT, v_rot(k), "rot_pre_reset");
      for (int i = 0; i < 2; i++) step(1'b1, C_ROT, V_IDLE, "rot_reset");
      for (int k = 0; k < ROTATE_CYCLES; k++) step(1'b0, C_ROT, v_rot(k), "rot_after_reset");
      step(1'b0, C_ROT, V_DONE, "rot_after_reset_done");
      step(1'b0, C_NONE, V_IDLE, "rot_after_release");

      // Priority: stop over rotate, rotate over both turns.
      step(1'b0, C_STOP | C_ROT, V_IDLE, "prio_stop_rot");
      for (int k = 0; k < 3; k++) step(1'b0, C_ROT | C_TL | C_TR, v_rot(k), "prio_rot_turns");
      step(1'b0, C_NONE, V_IDLE, "final_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

endmodule
